// File: rtl/gfx256_wbm_rw_master_pkg.sv
// Shared types and defaults for the GFX Wishbone read/write master.
// The optional watchdog is controlled by the GFX_WBM_TIMEOUT_EN macro.
package gfx256_wbm_rw_master_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } gfx_wbm_state_t;

  localparam int GFX_WBM_TIMEOUT_DEFAULT = 1023;
  localparam int GFX_WBM_WID_DEFAULT     = 256;

  // Width of a counter that must be able to hold the value lim.
  function automatic int gfx_wbm_cnt_width(input int lim);
    return (lim < 1) ? 1 : $clog2(lim + 1);
  endfunction

endpackage

// File: rtl/gfx256_wbm_rw_master_if.sv
// Arbiter-side request/ack signals and Wishbone master signals of the GFX bus master.
// Signal suffixes are from the master's point of view; the slave modport is the environment.
interface gfx256_wbm_rw_master_if #(
  parameter int WID = 256
);

  logic               read_request_i;
  logic               write_request_i;
  logic [31:0]        addr_i;
  logic               we_i;
  logic [WID/8-1:0]   sel_i;
  logic [WID-1:0]     dat_i;
  logic [WID-1:0]     dat_o;
  logic               ack_o;
  logic               err_o;
  logic               busy_o;

  logic               wb_cyc_o;
  logic               wb_stb_o;
  logic               wb_we_o;
  logic [WID/8-1:0]   wb_sel_o;
  logic [31:0]        wb_adr_o;
  logic [WID-1:0]     wb_dat_o;
  logic [WID-1:0]     wb_dat_i;
  logic               wb_ack_i;
  logic               wb_err_i;

  modport master (
    input  read_request_i, write_request_i, addr_i, we_i, sel_i, dat_i,
    input  wb_dat_i, wb_ack_i, wb_err_i,
    output dat_o, ack_o, err_o, busy_o,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o
  );

  modport slave (
    output read_request_i, write_request_i, addr_i, we_i, sel_i, dat_i,
    output wb_dat_i, wb_ack_i, wb_err_i,
    input  dat_o, ack_o, err_o, busy_o,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o, wb_adr_o, wb_dat_o
  );

endinterface

// File: rtl/gfx256_wbm_rw_master.sv
// Wishbone classic master: one held arbiter request becomes one registered bus cycle.
// Define GFX_WBM_TIMEOUT_EN to abort bus cycles the slave never answers.
module gfx256_wbm_rw_master
  import gfx256_wbm_rw_master_pkg::*;
#(
  parameter int WID     = GFX_WBM_WID_DEFAULT,
  parameter int TIMEOUT = GFX_WBM_TIMEOUT_DEFAULT
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  gfx256_wbm_rw_master_if.master        bus_if
);

  gfx_wbm_state_t     state_q;
  logic               cyc_q;
  logic               we_q;
  logic [WID/8-1:0]   sel_q;
  logic [31:0]        adr_q;
  logic [WID-1:0]     wdat_q;
  logic [WID-1:0]     rdat_q;
  logic               ack_q;
  logic               err_q;

  logic               req_any;
  logic               slave_done;
  logic               timeout_hit;
  logic               bus_end;
  logic               unused_we;

  // Direction comes from the request lines; the arbiter's we_i is informational only.
  assign unused_we  = bus_if.we_i;

  assign req_any    = bus_if.read_request_i | bus_if.write_request_i;
  assign slave_done = bus_if.wb_ack_i | bus_if.wb_err_i;
  assign bus_end    = slave_done | timeout_hit;

`ifdef GFX_WBM_TIMEOUT_EN
  localparam int TW = gfx_wbm_cnt_width(TIMEOUT);

  logic [TW-1:0] tmo_q;
  logic [TW-1:0] tmo_d;

  // Abort on the edge where the count of silent BUS cycles would reach TIMEOUT.
  assign timeout_hit = (state_q == BUS) && !slave_done && (tmo_q == TW'(TIMEOUT - 1));

  always_comb begin
    tmo_d = '0;
    if ((state_q == BUS) && !slave_done && !timeout_hit) begin
      tmo_d = tmo_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      adr_q   <= '0;
      wdat_q  <= '0;
      rdat_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_any) begin
            adr_q   <= bus_if.addr_i;
            sel_q   <= bus_if.sel_i;
            wdat_q  <= bus_if.dat_i;
            we_q    <= bus_if.write_request_i;
            cyc_q   <= 1'b1;
            state_q <= BUS;
          end
        end
        BUS: begin
          if (bus_end) begin
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            ack_q   <= 1'b1;
            err_q   <= bus_if.wb_err_i | timeout_hit;
            state_q <= DONE;
            // Only a clean read updates dat_o; an ack together with err counts as an error.
            if (!we_q && bus_if.wb_ack_i && !bus_if.wb_err_i) begin
              rdat_q <= bus_if.wb_dat_i;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          cyc_q   <= 1'b0;
          we_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus_if.wb_cyc_o = cyc_q;
  assign bus_if.wb_stb_o = cyc_q;
  assign bus_if.wb_we_o  = we_q;
  assign bus_if.wb_sel_o = sel_q;
  assign bus_if.wb_adr_o = adr_q;
  assign bus_if.wb_dat_o = wdat_q;
  assign bus_if.dat_o    = rdat_q;
  assign bus_if.ack_o    = ack_q;
  assign bus_if.err_o    = err_q;
  assign bus_if.busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_gfx256_wbm_rw_master.sv
// Directed and randomized bench for gfx256_wbm_rw_master against a transaction-level model.
// Build with GFX_WBM_TIMEOUT_EN to check the watchdog abort instead of the indefinite wait.
module tb_gfx256_wbm_rw_master;

  localparam int WID = 256;
  localparam int SW  = WID / 8;
  localparam int TMO = 8;

  logic clk;
  logic rst_n;
  int   n_cmp = 0;
  int   n_err = 0;

  // Model of dat_o: last cleanly completed read, zero after reset.
  logic [WID-1:0] exp_dat = '0;

  gfx256_wbm_rw_master_if #(.WID(WID)) bus_if ();

  gfx256_wbm_rw_master #(
    .WID     (WID),
    .TIMEOUT (TMO)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus_if  (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, summary not printed");
    $fatal(1, "time limit");
  end

  task automatic chk(input string tag, input logic [WID-1:0] obs, input logic [WID-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [WID-1:0] rnd_w();
    logic [WID-1:0] r;
    for (int i = 0; i < WID / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // One complete transfer: issue, waits, slave response, DONE, back to IDLE.
  task automatic txn(input bit rd, input bit wr, input logic [31:0] a, input logic [SW-1:0] s,
                     input logic [WID-1:0] d, input int waits, input bit serr,
                     input logic [WID-1:0] rdat, input bit hold);
    @(negedge clk);
    bus_if.read_request_i  = rd;
    bus_if.write_request_i = wr;
    bus_if.we_i            = wr;
    bus_if.addr_i          = a;
    bus_if.sel_i           = s;
    bus_if.dat_i           = d;
    @(posedge clk); #1;
    chk("issue_cyc",  bus_if.wb_cyc_o, 1);
    chk("issue_stb",  bus_if.wb_stb_o, 1);
    chk("issue_we",   bus_if.wb_we_o, wr);
    chk("issue_adr",  bus_if.wb_adr_o, a);
    chk("issue_sel",  bus_if.wb_sel_o, s);
    chk("issue_busy", bus_if.busy_o, 1);
    chk("issue_ack",  bus_if.ack_o, 0);
    if (wr) chk("issue_wdat", bus_if.wb_dat_o, d);
    for (int i = 0; i < waits; i++) begin
      @(posedge clk); #1;
      chk("wait_cyc", bus_if.wb_cyc_o, 1);
      chk("wait_ack", bus_if.ack_o, 0);
      chk("wait_adr", bus_if.wb_adr_o, a);
      if (wr) chk("wait_wdat", bus_if.wb_dat_o, d);
    end
    @(negedge clk);
    bus_if.wb_ack_i = serr ? 1'($urandom_range(0, 1)) : 1'b1;
    bus_if.wb_err_i = serr;
    bus_if.wb_dat_i = rdat;
    if (!hold) begin
      bus_if.read_request_i  = 1'b0;
      bus_if.write_request_i = 1'b0;
    end
    @(posedge clk); #1;
    if (!wr && !serr) exp_dat = rdat;
    chk("done_ack",  bus_if.ack_o, 1);
    chk("done_err",  bus_if.err_o, serr);
    chk("done_cyc",  bus_if.wb_cyc_o, 0);
    chk("done_stb",  bus_if.wb_stb_o, 0);
    chk("done_we",   bus_if.wb_we_o, 0);
    chk("done_dat",  bus_if.dat_o, exp_dat);
    chk("done_busy", bus_if.busy_o, 1);
    @(negedge clk);
    bus_if.wb_ack_i = 1'b0;
    bus_if.wb_err_i = 1'b0;
    bus_if.wb_dat_i = rnd_w();
    @(posedge clk); #1;
    chk("idle_ack",  bus_if.ack_o, 0);
    chk("idle_err",  bus_if.err_o, 0);
    chk("idle_busy", bus_if.busy_o, 0);
    chk("idle_cyc",  bus_if.wb_cyc_o, 0);
    chk("idle_dat",  bus_if.dat_o, exp_dat);
  endtask

  initial begin
    logic [WID-1:0] d;
    logic [SW-1:0]  all_sel;
    int kind;
    all_sel = '1;
    rst_n = 1'b0;
    bus_if.read_request_i  = 1'b0;
    bus_if.write_request_i = 1'b0;
    bus_if.we_i            = 1'b0;
    bus_if.addr_i          = '0;
    bus_if.sel_i           = '0;
    bus_if.dat_i           = '0;
    bus_if.wb_dat_i        = '0;
    bus_if.wb_ack_i        = 1'b0;
    bus_if.wb_err_i        = 1'b0;
    #3;
    chk("rst_cyc",  bus_if.wb_cyc_o, 0);
    chk("rst_stb",  bus_if.wb_stb_o, 0);
    chk("rst_ack",  bus_if.ack_o, 0);
    chk("rst_err",  bus_if.err_o, 0);
    chk("rst_busy", bus_if.busy_o, 0);
    chk("rst_dat",  bus_if.dat_o, 0);
    chk("rst_adr",  bus_if.wb_adr_o, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Error on a read straight after reset: dat_o must stay zero.
    txn(1, 0, 32'h0000_2000, all_sel, '0, 1, 1, rnd_w(), 0);
    // Zero-wait read.
    d = 256'hA5;
    txn(1, 0, 32'h0000_1000, all_sel, '0, 0, 0, d, 0);
    // Write with three wait states; dat_o untouched.
    d = 256'h1234;
    txn(0, 1, 32'h0000_3000, all_sel, d, 3, 0, rnd_w(), 0);
    // Both requests, held through DONE: write wins and is reissued only from IDLE.
    d = rnd_w();
    txn(1, 1, 32'h0000_0040, all_sel, d, 0, 0, rnd_w(), 1);
    txn(1, 1, 32'h0000_0040, all_sel, d, 1, 0, rnd_w(), 0);

    for (int n = 0; n < 30; n++) begin
      kind = $urandom_range(0, 2);
      txn(kind != 1, kind != 0, $urandom, SW'({$urandom, $urandom}) , rnd_w(),
          $urandom_range(0, 3), ($urandom_range(0, 4) == 0), rnd_w(), 0);
    end

    // Unanswered read: watchdog abort when compiled in, otherwise indefinite wait.
    @(negedge clk);
    bus_if.read_request_i = 1'b1;
    bus_if.addr_i         = 32'h0000_5000;
    @(posedge clk); #1;
    chk("stall_cyc0", bus_if.wb_cyc_o, 1);
`ifdef GFX_WBM_TIMEOUT_EN
    for (int i = 1; i <= TMO; i++) begin
      @(posedge clk); #1;
      chk("tmo_cyc", bus_if.wb_cyc_o, (i < TMO) ? 1 : 0);
      chk("tmo_ack", bus_if.ack_o, (i == TMO) ? 1 : 0);
      chk("tmo_err", bus_if.err_o, (i == TMO) ? 1 : 0);
    end
    chk("tmo_dat", bus_if.dat_o, exp_dat);
    @(negedge clk);
    bus_if.read_request_i = 1'b0;
`else
    for (int i = 0; i < 120; i++) begin
      @(posedge clk); #1;
      chk("stall_cyc", bus_if.wb_cyc_o, 1);
      chk("stall_ack", bus_if.ack_o, 0);
    end
    @(negedge clk);
    bus_if.read_request_i = 1'b0;
    bus_if.wb_ack_i       = 1'b1;
    bus_if.wb_dat_i       = 256'h77;
    exp_dat               = 256'h77;
    @(posedge clk); #1;
    chk("stall_end_ack", bus_if.ack_o, 1);
    chk("stall_end_dat", bus_if.dat_o, exp_dat);
    @(negedge clk);
    bus_if.wb_ack_i = 1'b0;
`endif
    @(posedge clk); #1;
    chk("stall_idle", bus_if.busy_o, 0);

    // Reset in the middle of a bus cycle.
    @(negedge clk);
    bus_if.write_request_i = 1'b1;
    bus_if.addr_i          = 32'h0000_6000;
    @(posedge clk); #1;
    chk("mid_cyc_pre", bus_if.wb_cyc_o, 1);
    #2;
    rst_n = 1'b0;
    #1;
    exp_dat = '0;
    chk("mid_cyc",  bus_if.wb_cyc_o, 0);
    chk("mid_stb",  bus_if.wb_stb_o, 0);
    chk("mid_ack",  bus_if.ack_o, 0);
    chk("mid_busy", bus_if.busy_o, 0);
    chk("mid_dat",  bus_if.dat_o, exp_dat);
    @(negedge clk);
    bus_if.write_request_i = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("post_rst_ack",  bus_if.ack_o, 0);
      chk("post_rst_busy", bus_if.busy_o, 0);
    end

    // One more read to confirm normal operation after the reset.
    txn(1, 0, 32'h0000_7000, all_sel, '0, 2, 0, rnd_w(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gfx256_wbm_rw_master.md
Name: gfx256_wbm_rw_master

Overview:
Wishbone classic master sitting between the GFX read/write arbiter and the external memory bus. It accepts one level-held read or write request at a time from the arbiter side. It converts the request into a single registered Wishbone cycle and returns a one-cycle ack with registered read data. It is the bus-facing responder to the arbiter's request/ack interface.

Parameters:
WID, 256, data bus width in bits; sel width is WID/8.
TIMEOUT, 1023, watchdog limit in clocks; used only when the optional feature is compiled in.

Ports:
clk_i  in  1  system clock.
rst_n_i  in  1  reset; asynchronous, active-low.
read_request_i  in  1  arbiter read request, held until ack_o.
write_request_i  in  1  arbiter write request, held until ack_o.
addr_i  in  32  byte address from arbiter.
we_i  in  1  write enable from arbiter; informational, direction comes from the request lines.
sel_i  in  WID/8  byte selects.
dat_i  in  WID  write data from arbiter.
dat_o  out  WID  registered read data to arbiter.
ack_o  out  1  one-cycle completion pulse to arbiter.
err_o  out  1  one-cycle pulse coincident with ack_o when the cycle ended in error.
busy_o  out  1  high while not IDLE.
wb_cyc_o  out  1  Wishbone CYC.
wb_stb_o  out  1  Wishbone STB.
wb_we_o  out  1  Wishbone WE.
wb_sel_o  out  WID/8  Wishbone SEL.
wb_adr_o  out  32  Wishbone ADR.
wb_dat_o  out  WID  Wishbone write data.
wb_dat_i  in  WID  Wishbone read data.
wb_ack_i  in  1  Wishbone ACK.
wb_err_i  in  1  Wishbone ERR.

Behaviour:
- Reset (asynchronous, on rst_n_i low): all outputs 0, state IDLE, timeout counter 0. Reset mid-cycle drops wb_cyc_o and wb_stb_o immediately; no ack_o is produced.
- States: IDLE, BUS, DONE.
- IDLE, with read_request_i or write_request_i high at edge N:
  - Register addr_i, sel_i and dat_i onto wb_adr_o, wb_sel_o and wb_dat_o.
  - wb_we_o = write_request_i.
  - wb_cyc_o and wb_stb_o go high from N+1; go to BUS.
  - If both requests are high, the write wins.
- BUS:
  - Outputs are held stable while wb_ack_i and wb_err_i are both low.
  - On the edge where wb_ack_i or wb_err_i is sampled high: drop cyc/stb/we, pulse ack_o for one cycle, go to DONE.
  - On a read, latch wb_dat_i into dat_o on that same edge.
  - err_o = wb_err_i sampled on that edge.
  - If ack and err are high together, the cycle is treated as an error (err_o=1).
  - Minimum request-to-ack_o latency is 2 clocks (zero-wait slave acking in the first BUS cycle).
- Request deasserted while in BUS: the bus cycle still completes and ack_o is still pulsed.
- DONE: exactly one cycle, then IDLE. A request seen during DONE is ignored; this gives the arbiter a cycle to drop or change its held request and prevents a duplicate issue.
- dat_o holds its value until the next read completes; writes do not alter it.
- busy_o = (state != IDLE).
- Back-to-back throughput is 1 transfer per 3 clocks with zero-wait slaves.

Optional Feature:
- Macro GFX_WBM_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to BUS and increments each BUS cycle without ack/err.
  - When it reaches TIMEOUT, the cycle is aborted: cyc/stb drop, ack_o=1 and err_o=1 for one cycle, dat_o unchanged, go to DONE.
  - Counter width is $clog2(TIMEOUT+1).
- Undefined: no counter; BUS waits indefinitely for ack/err.

Decomposition:
- gfx256_pkg additions:
  - state enum typedef gfx_wbm_state_t {IDLE, BUS, DONE}.
  - localparam GFX_WBM_TIMEOUT_DEFAULT = 1023.
- No sub-module; a single always_ff state machine plus the optional counter.

Test Plan:
- Read, zero-wait: read_request_i=1, addr_i=32'h0000_1000, slave acks in the first BUS cycle with wb_dat_i=WID'hA5 -> cyc/stb high from N+1; ack_o at N+2 with dat_o=WID'hA5; wb_adr_o=32'h0000_1000; DONE then IDLE.
- Write, 3 wait states: write_request_i=1, sel_i all ones, dat_i=WID'h1234 -> wb_we_o=1 and wb_dat_o=WID'h1234 stable for 4 cycles; ack_o one pulse; dat_o unchanged.
- Both requests high with addr_i=32'h40 -> write issued (wb_we_o=1); a request still held through DONE is not reissued until IDLE.
- Slave asserts wb_err_i on a read -> ack_o=1 and err_o=1 on the same cycle; dat_o keeps its previous value (0 after reset).
- rst_n_i pulled low during BUS -> wb_cyc_o=0 immediately (asynchronous); no ack_o; state IDLE after release.
- With GFX_WBM_TIMEOUT_EN and TIMEOUT=8, slave never acks -> abort after 8 BUS cycles with ack_o=1 and err_o=1; without the macro, cyc stays high for 100+ cycles.
